input_debounce4: RTL and testbench
==================================

INPUT_DEBOUNCE4 -- requirements
Module: input_debounce4

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels; the default matches the four inputs of the 4-input AND stage downstream.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive mismatching clock edges required to accept a new level; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 raw_in  input  WIDTH  asynchronous, bouncy inputs, e.g. switches or buttons.
REQ-006 stable_out  output  WIDTH  debounced level per channel; drives in1..in4 of the AND stage downstream.
REQ-007 rise_pulse  output  WIDTH  one-cycle high when the matching stable_out bit goes 0->1.
REQ-008 fall_pulse  output  WIDTH  one-cycle high when the matching stable_out bit goes 1->0.

Function
REQ-009 Each channel i SHALL operate independently, with its own sample s[i], accepted level q[i] (= stable_out[i]) and counter cnt[i].
REQ-010 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps because it clears at terminal count.
REQ-011 On an edge where s[i]==q[i]: cnt[i]<=0 and q[i] holds.
REQ-012 On an edge where s[i]!=q[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i] increments and q[i] holds.
REQ-013 On an edge where s[i]!=q[i] and cnt[i]==DEBOUNCE_CYCLES-1: q[i]<=s[i] and cnt[i]<=0, so q updates on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
REQ-014 A mismatch lasting fewer than DEBOUNCE_CYCLES edges SHALL be discarded: stable_out does not change and the counter restarts from 0 at the next mismatch.
REQ-015 rise_pulse[i]/fall_pulse[i] SHALL be registered, asserted in the same cycle stable_out[i] takes its new value, and deasserted the next cycle; they are never both high.
REQ-016 Channels settling on the same edge SHALL produce their pulses in that same cycle.
REQ-017 All outputs SHALL be driven directly from flops, with no combinational path from raw_in to any output.

Reset
REQ-018 While rst_n==0 at a rising edge: stable_out=0, rise_pulse=0, fall_pulse=0, every cnt=0, and the synchronizer flops (if present) =0.
REQ-019 Reset asserted mid-count SHALL abandon any pending transition; no pulse is emitted for it.
REQ-020 After reset release, a raw_in held at 1 SHALL be accepted as a 0->1 transition under REQ-013, producing rise_pulse.

Configuration
REQ-021 Macro INPUT_DEBOUNCE_SYNC_EN defined: each raw_in bit passes through a 2-flop synchronizer and s[i] is the second flop, adding exactly 2 cycles of latency.
REQ-022 INPUT_DEBOUNCE_SYNC_EN undefined: s[i]=raw_in[i] sampled directly, the caller guarantees synchronous inputs, and latency equals DEBOUNCE_CYCLES edges.

Structure
REQ-023 Package input_debounce_pkg SHALL hold DEFAULT_WIDTH=4, DEFAULT_DEBOUNCE_CYCLES=16 and the counter-width function.
REQ-024 Sub-module debounce_bit SHALL implement one channel (optional synchronizer, counter, q, pulses) and be instantiated WIDTH times via generate.
REQ-025 DEBOUNCE_CYCLES<2 SHALL cause an elaboration-time error.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, macro undefined unless stated)
REQ-026 Reset: rst_n=0 for 2 edges with raw_in=4'hF -> stable_out=0, pulses=0; release -> stable_out=4'hF on the 4th edge, with rise_pulse=4'hF for that single cycle.
REQ-027 Glitch: from stable 4'h0, raw_in[0]=1 for 3 edges then 0 -> stable_out stays 4'h0 and no pulse.
REQ-028 Bounce: raw_in[2] toggles 1,0,1,1,1,1 on successive edges -> stable_out[2] rises on the 4th consecutive 1 (the 6th edge), with a single rise_pulse.
REQ-029 Simultaneous: from 4'h3, raw_in=4'hC held -> on the 4th edge stable_out=4'hC, rise_pulse=4'hC, fall_pulse=4'h3, all in the same cycle.
REQ-030 Reset mid-count: raw_in[1]=1 for 3 edges, rst_n=0 on the 4th, then released -> no pulse at the 4th edge; stable_out[1] rises 4 edges after release.
REQ-031 Macro defined: repeat REQ-027 and REQ-029 -> identical outcomes, with every output transition delayed by exactly 2 cycles.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// Shared defaults and counter sizing for the input_debounce4 block.
// The optional input synchronizer is enabled with `define INPUT_DEBOUNCE_SYNC_EN.
package input_debounce_pkg;

    localparam int DEFAULT_WIDTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int MIN_DEBOUNCE_CYCLES     = 2;
    localparam int MAX_DEBOUNCE_CYCLES     = 65535;

    // Counter only ever reaches cycles-1, so $clog2(cycles) bits are enough.
    function automatic int cnt_width(input int cycles);
        return (cycles < MIN_DEBOUNCE_CYCLES) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: optional 2-flop synchronizer, mismatch counter, accepted level, edge pulses.
// `define INPUT_DEBOUNCE_SYNC_EN inserts the synchronizer ahead of the counter.
module debounce_bit
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          w_sample;
    logic          w_mismatch;
    logic          w_terminal;
    logic [CW-1:0] w_cnt_next;
    logic          w_q_next;
    logic          w_settle;

    logic [CW-1:0] r_cnt;
    logic          r_q;
    logic          r_rise;
    logic          r_fall;

`ifdef INPUT_DEBOUNCE_SYNC_EN
    logic r_sync_meta;
    logic r_sync_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_out  <= 1'b0;
        end else begin
            r_sync_meta <= i_raw;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_sample = r_sync_out;
`else
    assign w_sample = i_raw;
`endif

    assign w_mismatch = w_sample ^ r_q;
    assign w_terminal = (r_cnt == TERMINAL);

    // Any edge where the sample agrees with the accepted level restarts the count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_cnt_next = '0;
        w_q_next   = r_q;
        w_settle   = 1'b0;
        if (w_mismatch) begin
            if (w_terminal) begin
                w_q_next = w_sample;
                w_settle = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_q    <= w_q_next;
            r_rise <= w_settle &  w_sample;
            r_fall <= w_settle & ~w_sample;
        end
    end

    assign o_stable = r_q;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/input_debounce4.sv
// Multi-channel debouncer feeding the 4-input AND stage; one debounce_bit per channel.
// `define INPUT_DEBOUNCE_SYNC_EN adds a 2-flop synchronizer (2 cycles latency) per channel.
module input_debounce4
    import input_debounce_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    if ((DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) || (DEBOUNCE_CYCLES > MAX_DEBOUNCE_CYCLES)) begin : g_bad_cycles
        $error("input_debounce4: DEBOUNCE_CYCLES=%0d outside 2..65535", DEBOUNCE_CYCLES);
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("input_debounce4: WIDTH=%0d must be at least 1", WIDTH);
    end

    // Channels are fully independent; outputs come straight from each channel's flops.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_raw    (raw_in[gi]),
            .o_stable (stable_out[gi]),
            .o_rise   (rise_pulse[gi]),
            .o_fall   (fall_pulse[gi])
        );
    end

endmodule

// File: tb/tb_input_debounce4.sv
// Self-checking bench for input_debounce4 (WIDTH=4, DEBOUNCE_CYCLES=4): directed cases plus random stimulus.
// Reference model: a level flips once the last N samples since reset all disagree with it.
module tb_input_debounce4;

    localparam int W = 4;
    localparam int N = 4;
`ifdef INPUT_DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_rise  = '0;
    logic [W-1:0] m_fall  = '0;
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_pipe[$];

    always #5 clk = ~clk;

    input_debounce4 #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        assert (act === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Samples reach the counter LAT edges after raw_in; reset clears history and pipeline.
    task automatic model_edge(input logic [W-1:0] raw, input logic rst);
        logic [W-1:0] s;
        bit           flip;
        m_rise = '0;
        m_fall = '0;
        if (!rst) begin
            m_level = '0;
            m_hist.delete();
            m_pipe.delete();
            repeat (LAT) m_pipe.push_back('0);
        end else begin
            m_pipe.push_back(raw);
            s = m_pipe.pop_front();
            m_hist.push_back(s);
            if (m_hist.size() > N) void'(m_hist.pop_front());
            if (m_hist.size() == N) begin
                for (int ch = 0; ch < W; ch++) begin
                    flip = 1'b1;
                    for (int j = 0; j < N; j++)
                        if (m_hist[j][ch] == m_level[ch]) flip = 1'b0;
                    if (flip) begin
                        m_level[ch] = ~m_level[ch];
                        if (m_level[ch]) m_rise[ch] = 1'b1;
                        else             m_fall[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic [W-1:0] raw, input logic rst);
        raw_in = raw;
        rst_n  = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
        check("model_stable", stable_out, m_level);
        check("model_rise", rise_pulse, m_rise);
        check("model_fall", fall_pulse, m_fall);
        check("pulse_exclusive", rise_pulse & fall_pulse, '0);
    endtask

    initial begin
        logic [5:0]   bounce;
        logic [W-1:0] rv;
        logic         rr;
        int           hold;

        // Reset with all inputs high.
        for (int e = 0; e < 2; e++) begin
            tick(4'hF, 1'b0);
            check("reset_stable", stable_out, 4'h0);
            check("reset_rise", rise_pulse, 4'h0);
            check("reset_fall", fall_pulse, 4'h0);
        end

        // Release: held-high inputs are accepted on the N-th edge.
        for (int e = 1; e < N + LAT; e++) begin
            tick(4'hF, 1'b1);
            check("release_wait", stable_out, 4'h0);
            check("release_wait_rise", rise_pulse, 4'h0);
        end
        tick(4'hF, 1'b1);
        check("release_stable", stable_out, 4'hF);
        check("release_rise", rise_pulse, 4'hF);
        tick(4'hF, 1'b1);
        check("release_rise_drop", rise_pulse, 4'h0);

        // Return to all-low.
        for (int e = 1; e <= N + LAT; e++) tick(4'h0, 1'b1);
        check("to_zero_stable", stable_out, 4'h0);
        check("to_zero_fall", fall_pulse, 4'hF);
        tick(4'h0, 1'b1);

        // Glitch shorter than N edges is discarded.
        for (int e = 0; e < N - 1; e++) begin
            tick(4'h1, 1'b1);
            check("glitch_stable", stable_out, 4'h0);
        end
        for (int e = 0; e < N + LAT + 2; e++) begin
            tick(4'h0, 1'b1);
            check("glitch_after_stable", stable_out, 4'h0);
            check("glitch_after_rise", rise_pulse, 4'h0);
        end

        // Bounce on channel 2: 1,0,1,1,1,1 -> rises on the 6th edge (plus latency).
        bounce = 6'b111101;
        for (int e = 1; e <= 6 + LAT + 1; e++) begin
            tick((e <= 6) ? (bounce[e-1] ? 4'h4 : 4'h0) : 4'h4, 1'b1);
            check("bounce_rise", rise_pulse, (e == 6 + LAT) ? 4'h4 : 4'h0);
            check("bounce_stable", stable_out, (e >= 6 + LAT) ? 4'h4 : 4'h0);
        end

        // Move to 4'h3, then switch every channel at once to 4'hC.
        for (int e = 0; e <= N + LAT; e++) tick(4'h3, 1'b1);
        check("pre_simul_stable", stable_out, 4'h3);
        for (int e = 1; e <= N + LAT; e++) begin
            tick(4'hC, 1'b1);
            if (e < N + LAT) check("simul_wait", stable_out, 4'h3);
        end
        check("simul_stable", stable_out, 4'hC);
        check("simul_rise", rise_pulse, 4'hC);
        check("simul_fall", fall_pulse, 4'h3);
        tick(4'hC, 1'b1);
        check("simul_pulse_drop", rise_pulse | fall_pulse, 4'h0);

        // Reset mid-count abandons the pending transition.
        for (int e = 0; e <= N + LAT; e++) tick(4'h0, 1'b1);
        for (int e = 0; e < N - 1; e++) tick(4'h2, 1'b1);
        check("midcnt_pre_stable", stable_out, 4'h0);
        tick(4'h2, 1'b0);
        check("midcnt_rst_stable", stable_out, 4'h0);
        check("midcnt_rst_rise", rise_pulse, 4'h0);
        for (int e = 1; e <= N + LAT; e++) begin
            tick(4'h2, 1'b1);
            check("midcnt_after_stable", stable_out, (e == N + LAT) ? 4'h2 : 4'h0);
            check("midcnt_after_rise", rise_pulse, (e == N + LAT) ? 4'h2 : 4'h0);
        end

        // Random levels held for random spans, with occasional resets.
        for (int r = 0; r < 120; r++) begin
            rv   = W'($urandom);
            hold = $urandom_range(1, 7);
            rr   = ($urandom_range(0, 24) != 0);
            for (int h = 0; h < hold; h++) tick(rv, (h == 0) ? rr : 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
